// File: rtl/medicine_pkg.sv
// Shared types and helpers for the multi-channel medicine scheduler.
// Channel state encoding and counter width helper.
package medicine_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_ALERT   = 2'd1,
    ST_SNOOZED = 2'd2,
    ST_DONE    = 2'd3
  } ch_state_e;

  // Bits needed to hold 0..max_val-1, never less than one bit.
  function automatic int width_of(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/medicine_channel.sv
// One medicine channel: dose interval, reminder window, snooze and dose limit.
// state   | meaning
// WAIT    | counting the interval to the next reminder
// ALERT   | reminder asserted, window timer running
// SNOOZED | reminder suppressed after a snooze, snooze timer running
// DONE    | dose limit reached, only restart or reset leaves
module medicine_channel
  import medicine_pkg::*;
#(
  parameter int INTERVAL_CYCLES = 600,
  parameter int REMIND_CYCLES   = 100,
  parameter int SNOOZE_CYCLES   = 50,
  parameter int MAX_SNOOZE      = 2,
  parameter int MAX_DOSES       = 3,
  localparam int DOSE_W         = width_of(MAX_DOSES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              ch_enable,
  input  logic              ack,
  input  logic              snooze,
  input  logic              restart,
  output logic              reminder,
  output logic              missed,
  output logic              done,
  output logic [DOSE_W-1:0] dose_count,
  output logic              reminder_nxt
);

  localparam int IW = width_of(INTERVAL_CYCLES);
  localparam int AW = width_of(REMIND_CYCLES);
  localparam int SW = width_of(SNOOZE_CYCLES);
  localparam int UW = width_of(MAX_SNOOZE + 1);

  localparam logic [IW-1:0]     INT_LAST   = IW'(INTERVAL_CYCLES - 1);
  localparam logic [AW-1:0]     ALERT_LAST = AW'(REMIND_CYCLES - 1);
  localparam logic [SW-1:0]     SNZ_LAST   = SW'(SNOOZE_CYCLES - 1);
  localparam logic [DOSE_W-1:0] DOSE_MAX   = DOSE_W'(MAX_DOSES);

  ch_state_e         state_q, state_d;
  logic [IW-1:0]     int_cnt_q, int_cnt_d;
  logic [AW-1:0]     alert_cnt_q, alert_cnt_d;
  logic [SW-1:0]     snz_cnt_q, snz_cnt_d;
  logic [UW-1:0]     snz_used_q, snz_used_d;
  logic [DOSE_W-1:0] dose_q, dose_d;
  logic              missed_q, missed_d;
  logic              reminder_q, reminder_d;
  logic              done_q, done_d;
  logic              dose_evt;

  always_comb begin
    state_d     = state_q;
    int_cnt_d   = int_cnt_q;
    alert_cnt_d = alert_cnt_q;
    snz_cnt_d   = snz_cnt_q;
    snz_used_d  = snz_used_q;
    dose_d      = dose_q;
    missed_d    = missed_q;
    dose_evt    = 1'b0;

    if (restart) begin
      state_d     = ST_WAIT;
      int_cnt_d   = '0;
      alert_cnt_d = '0;
      snz_cnt_d   = '0;
      snz_used_d  = '0;
      dose_d      = '0;
      missed_d    = 1'b0;
    end else if (!ch_enable) begin
      // Schedule history is kept; a finished channel stays finished.
      state_d     = (state_q == ST_DONE) ? ST_DONE : ST_WAIT;
      int_cnt_d   = '0;
      alert_cnt_d = '0;
      snz_cnt_d   = '0;
      snz_used_d  = '0;
    end else if (enable) begin
      case (state_q)
        ST_WAIT: begin
          if (int_cnt_q == INT_LAST) begin
            state_d     = ST_ALERT;
            int_cnt_d   = '0;
            alert_cnt_d = '0;
            snz_used_d  = '0;
          end else begin
            int_cnt_d = int_cnt_q + 1'b1;
          end
        end
        ST_ALERT: begin
          if (ack) begin
            dose_evt = 1'b1;
          end else if (alert_cnt_q == ALERT_LAST) begin
            dose_evt = 1'b1;
            missed_d = 1'b1;
          end else if (snooze && (int'(snz_used_q) < MAX_SNOOZE)) begin
            state_d    = ST_SNOOZED;
            snz_used_d = snz_used_q + 1'b1;
            snz_cnt_d  = '0;
          end else begin
            alert_cnt_d = alert_cnt_q + 1'b1;
          end
        end
        ST_SNOOZED: begin
          if (ack) begin
            dose_evt = 1'b1;
          end else if (snz_cnt_q == SNZ_LAST) begin
            state_d     = ST_ALERT;
            alert_cnt_d = '0;
            snz_cnt_d   = '0;
          end else begin
            snz_cnt_d = snz_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase

      if (dose_evt) begin
        int_cnt_d   = '0;
        alert_cnt_d = '0;
        snz_cnt_d   = '0;
        if (dose_q != DOSE_MAX) dose_d = dose_q + 1'b1;
        state_d = (int'(dose_q) + 1 >= MAX_DOSES) ? ST_DONE : ST_WAIT;
      end
    end
  end

  assign reminder_d   = (state_d == ST_ALERT);
  assign done_d       = (state_d == ST_DONE);
  assign reminder_nxt = reminder_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_WAIT;
      int_cnt_q   <= '0;
      alert_cnt_q <= '0;
      snz_cnt_q   <= '0;
      snz_used_q  <= '0;
      dose_q      <= '0;
      missed_q    <= 1'b0;
      reminder_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      int_cnt_q   <= int_cnt_d;
      alert_cnt_q <= alert_cnt_d;
      snz_cnt_q   <= snz_cnt_d;
      snz_used_q  <= snz_used_d;
      dose_q      <= dose_d;
      missed_q    <= missed_d;
      reminder_q  <= reminder_d;
      done_q      <= done_d;
    end
  end

  assign reminder   = reminder_q;
  assign missed     = missed_q;
  assign done       = done_q;
  assign dose_count = dose_q;

endmodule

// File: rtl/medicine_scheduler.sv
// Multi-channel medicine reminder scheduler: NUM_CH independent channels
// plus a registered summary reminder for the alert driver.
module medicine_scheduler
  import medicine_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int INTERVAL_CYCLES = 600,
  parameter int REMIND_CYCLES   = 100,
  parameter int SNOOZE_CYCLES   = 50,
  parameter int MAX_SNOOZE      = 2,
  parameter int MAX_DOSES       = 3,
  localparam int DOSE_W         = width_of(MAX_DOSES + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH-1:0]        ack,
  input  logic [NUM_CH-1:0]        snooze,
  input  logic [NUM_CH-1:0]        restart,
  output logic [NUM_CH-1:0]        reminder,
  output logic [NUM_CH-1:0]        missed,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH*DOSE_W-1:0] dose_count,
  output logic                     any_reminder
);

  logic [NUM_CH-1:0] reminder_nxt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    medicine_channel #(
      .INTERVAL_CYCLES(INTERVAL_CYCLES),
      .REMIND_CYCLES  (REMIND_CYCLES),
      .SNOOZE_CYCLES  (SNOOZE_CYCLES),
      .MAX_SNOOZE     (MAX_SNOOZE),
      .MAX_DOSES      (MAX_DOSES)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .ch_enable   (ch_enable[i]),
      .ack         (ack[i]),
      .snooze      (snooze[i]),
      .restart     (restart[i]),
      .reminder    (reminder[i]),
      .missed      (missed[i]),
      .done        (done[i]),
      .dose_count  (dose_count[i*DOSE_W +: DOSE_W]),
      .reminder_nxt(reminder_nxt[i])
    );
  end

  // Built from next-state reminders so it flips on the same edge as reminder.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_reminder <= 1'b0;
    else          any_reminder <= |reminder_nxt;
  end

endmodule

// File: tb/tb_medicine_scheduler.sv
// Scoreboard bench for medicine_scheduler: stimulus queues expected output
// snapshots; a negedge monitor pops one whenever any output changes.
module tb_medicine_scheduler;

  localparam int NCH = 2;
  localparam int DW  = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           enable;
  logic [NCH-1:0] ch_enable, ack, snooze, restart;
  logic [NCH-1:0] reminder, missed, done;
  logic [NCH*DW-1:0] dose_count;
  logic           any_reminder;

  medicine_scheduler #(
    .NUM_CH(NCH), .INTERVAL_CYCLES(10), .REMIND_CYCLES(4),
    .SNOOZE_CYCLES(3), .MAX_SNOOZE(1), .MAX_DOSES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ch_enable(ch_enable),
    .ack(ack), .snooze(snooze), .restart(restart), .reminder(reminder),
    .missed(missed), .done(done), .dose_count(dose_count),
    .any_reminder(any_reminder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    logic [1:0] rem;
    logic [1:0] mis;
    logic [1:0] dn;
    logic [3:0] dc;
    logic       any;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic mon_on = 1'b0;

  task automatic push(input int c, input logic [1:0] r, input logic [1:0] m,
                      input logic [1:0] d, input logic [3:0] dc);
    exp_t e;
    e.cyc = c; e.rem = r; e.mis = m; e.dn = d; e.dc = dc; e.any = |r;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor
  logic [10:0] prev, cur;
  logic        armed = 1'b0;
  always @(negedge clk) begin
    if (mon_on) begin
      cur = {reminder, missed, done, dose_count, any_reminder};
      if (!armed) begin
        prev  = cur;
        armed = 1'b1;
      end else if (cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got rem=%b mis=%b done=%b dc=%b any=%b",
                   cyc, reminder, missed, done, dose_count, any_reminder);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.rem !== reminder || e.mis !== missed ||
              e.dn !== done || e.dc !== dose_count || e.any !== any_reminder) begin
            bad++;
            $display("FAIL event got cyc=%0d rem=%b mis=%b done=%b dc=%b any=%b want cyc=%0d rem=%b mis=%b done=%b dc=%b any=%b",
                     cyc, reminder, missed, done, dose_count, any_reminder,
                     e.cyc, e.rem, e.mis, e.dn, e.dc, e.any);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, b, r, q;
    reset_n = 1'b1; enable = 1'b0; ch_enable = '0;
    ack = '0; snooze = '0; restart = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_reminder", 32'(reminder), 0);
    check("reset_missed", 32'(missed), 0);
    check("reset_done", 32'(done), 0);
    check("reset_dose_count", 32'(dose_count), 0);
    check("reset_any", 32'(any_reminder), 0);
    mon_on = 1'b1;
    @(posedge clk); #1;

    // Channel 0 alone: expiry then acknowledged second dose reaches the limit
    c0 = cyc;
    reset_n = 1'b1; enable = 1'b1; ch_enable = 2'b01;
    push(c0 + 10, 2'b01, 2'b00, 2'b00, 4'b0000);
    push(c0 + 14, 2'b00, 2'b01, 2'b00, 4'b0001);
    push(c0 + 24, 2'b01, 2'b01, 2'b00, 4'b0001);
    push(c0 + 26, 2'b00, 2'b01, 2'b01, 4'b0010);
    wait_to(c0 + 25); ack = 2'b01;
    wait_to(c0 + 26); ack = 2'b00;
    wait_to(c0 + 40);

    // Channel 1: snooze, fresh window, ignored second snooze, expiry
    b = cyc;
    ch_enable = 2'b11;
    push(b + 10, 2'b10, 2'b01, 2'b01, 4'b0010);
    push(b + 12, 2'b00, 2'b01, 2'b01, 4'b0010);
    push(b + 15, 2'b10, 2'b01, 2'b01, 4'b0010);
    push(b + 19, 2'b00, 2'b11, 2'b01, 4'b0110);
    wait_to(b + 11); snooze = 2'b10;
    wait_to(b + 12); snooze = 2'b00;
    wait_to(b + 15); snooze = 2'b10;
    wait_to(b + 19); snooze = 2'b00;
    wait_to(b + 22);

    // Channel 1 restart, then ack+snooze together and ack on the expiry cycle
    r = cyc;
    restart = 2'b10;
    push(r + 1,  2'b00, 2'b01, 2'b01, 4'b0010);
    push(r + 11, 2'b10, 2'b01, 2'b01, 4'b0010);
    push(r + 12, 2'b00, 2'b01, 2'b01, 4'b0110);
    push(r + 22, 2'b10, 2'b01, 2'b01, 4'b0110);
    push(r + 26, 2'b00, 2'b01, 2'b11, 4'b1010);
    wait_to(r + 1);  restart = 2'b00;
    wait_to(r + 11); ack = 2'b10; snooze = 2'b10;
    wait_to(r + 12); ack = 2'b00; snooze = 2'b00;
    wait_to(r + 25); ack = 2'b10;
    wait_to(r + 26); ack = 2'b00;
    wait_to(r + 30);

    // Restart channel 0 from DONE; freeze mid-alert; async reset mid-alert
    q = cyc;
    restart = 2'b01;
    push(q + 1,  2'b00, 2'b00, 2'b10, 4'b1000);
    push(q + 11, 2'b01, 2'b00, 2'b10, 4'b1000);
    push(q + 20, 2'b00, 2'b01, 2'b10, 4'b1001);
    push(q + 30, 2'b01, 2'b01, 2'b10, 4'b1001);
    push(q + 31, 2'b00, 2'b00, 2'b00, 4'b0000);
    wait_to(q + 1);  restart = 2'b00;
    wait_to(q + 12); enable = 1'b0; ack = 2'b01;
    wait_to(q + 17); enable = 1'b1; ack = 2'b00;
    wait_to(q + 31);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_reminder", 32'(reminder), 0);
    check("async_reset_any", 32'(any_reminder), 0);
    check("async_reset_missed", 32'(missed), 0);
    check("async_reset_done", 32'(done), 0);
    check("async_reset_dose_count", 32'(dose_count), 0);
    wait_to(q + 34);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
